alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute-stage wrapper around the ALU arithmetic/logic units (Adder, Subtractor, Compare,
//  LogicalShiftLeft32, LogicalShiftRight32, ArithmeticShiftRight32).
//  Latches operands from decode, drives them into the combinational units, selects one result
//  and registers it for the write-back stage, with valid/ready flow control on both sides.
//  Two-stage pipeline: operand latch (S1), result register (S2); sustains one op per cycle.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; fixed at 32 (the shifters are 32-bit only)
//  TAG_WIDTH   5   width of destination tag carried alongside the op (register index)
// PORTS
//  clk          in   1           clock; all state updates on rising edge
//  rst_n        in   1           reset, asynchronous, active-low
//  flush        in   1           synchronous pipeline flush (branch mispredict / exception)
//  in_valid     in   1           decode presents an op
//  in_ready     out  1           stage accepts an op this cycle
//  in_op        in   4           operation select (encoding in BEHAVIOUR)
//  in_a         in   DATA_WIDTH  operand A
//  in_b         in   DATA_WIDTH  operand B; for shifts only in_b[4:0] is used
//  in_tag       in   TAG_WIDTH   destination tag, passed through unchanged
//  out_valid    out  1           result register holds a valid result
//  out_ready    in   1           write-back consumes result this cycle
//  out_result   out  DATA_WIDTH  selected result
//  out_tag      out  TAG_WIDTH   tag of the op in out_result
//  out_illegal  out  1           op code was unassigned; out_result forced to 0
// BEHAVIOUR
//  Op encoding: 0 ADD a+b | 1 SUB a-b | 2 SLTU {31'b0,ltu} | 3 SLTS {31'b0,lts} | 4 AND
//   5 OR | 6 XOR | 7 LSL a<<b[4:0] | 8 LSR | 9 ASR | 10-15 illegal (result 0, out_illegal=1).
//  Add/sub wrap modulo 2^32; no carry/overflow outputs. SLTU/SLTS come from the Compare unit.
//  Reset (rst_n low, async): s1_valid=0, out_valid=0, out_result=0, out_tag=0, out_illegal=0;
//   S1 operand/op/tag registers cleared to 0. in_ready=1 from the first cycle after reset.
//  Handshakes: transfer when valid && ready at a rising edge. valid must not depend on ready.
//  s2_free   = !out_valid || out_ready
//  s1_adv    = s1_valid && s2_free
//  in_ready  = (!s1_valid || s2_free) && !flush   (combinational)
//  Accept at edge E0 -> S1 holds op; units compute during cycle; S1->S2 at edge E1;
//   out_valid high in the cycle after E1. Latency: 2 edges from accept to out_valid.
//  Back-to-back: with out_ready held high, one result per cycle, no bubbles.
//  Stall: out_valid && !out_ready -> out_result/out_tag/out_illegal held stable; S1 holds;
//   in_ready low only if S1 is also occupied (at most 2 ops buffered).
//  Simultaneous S2 drain and S1 advance in one edge: S2 reloads from S1, out_valid stays 1.
//  Simultaneous S1 advance and new accept: S1 reloads with new op, s1_valid stays 1.
//  flush (sync): at next edge s1_valid=0 and out_valid=0; any in_valid that cycle is not
//   accepted (in_ready forced 0); a result shown with out_valid && out_ready in the flush
//   cycle still counts as consumed. Data registers keep their values (don't-care).
//  rst_n asserted mid-operation: all in-flight ops discarded immediately, outputs to reset values.
//  Result mux is purely on the registered S1 op; no combinational path from in_* to out_*.
// TESTING
//  1 Reset then ADD a=0xFFFF_FFFF b=1 tag=3, out_ready=1 -> 2 edges later out_valid=1,
//    out_result=0, out_tag=3, out_illegal=0.
//  2 SLTS a=0x8000_0000 b=1 -> 1; SLTU same operands -> 0; ASR a=0x8000_0000 b=0x24 (amt 4)
//    -> 0xF800_0000; LSL a=1 b=31 -> 0x8000_0000.
//  3 Stream 8 ops in_valid=1, out_ready=1 -> 8 results on 8 consecutive cycles in order,
//    in_ready never deasserts.
//  4 out_ready=0 for 5 cycles while driving ops -> exactly 2 accepted, in_ready=0 afterwards,
//    out_result stable; release out_ready -> both drain in order, no loss/duplication.
//  5 flush with S1 and S2 full and in_valid=1 -> next cycle out_valid=0, s1 empty, that
//    input not accepted; following op completes normally.
//  6 in_op=12 a=5 b=7 -> out_result=0, out_illegal=1; rst_n low mid-stream -> out_valid=0
//    asynchronously, no stale result after release.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage: latches a decoded ALU op (S1), computes it combinationally from the S1
// registers and registers the selected result for write-back (S2), with valid/ready on both sides.
module alu_exec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_illegal
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLTU = 4'd2,
        OP_SLTS = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_LSL  = 4'd7,
        OP_LSR  = 4'd8,
        OP_ASR  = 4'd9
    } op_e;

    logic                  r_s1_valid;
    logic [3:0]            r_s1_op;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;
    logic [TAG_WIDTH-1:0]  r_s1_tag;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_result;
    logic [TAG_WIDTH-1:0]  r_out_tag;
    logic                  r_out_illegal;

    logic                  w_s2_free;
    logic                  w_s1_adv;
    logic                  w_accept;

    // Stage-to-stage handshake terms; S2 may drain and refill in the same edge.
    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = (!r_s1_valid || w_s2_free) && !flush;
    assign w_accept  = in_valid && in_ready;

    // Functional units, all fed from the S1 registers only.
    logic [DATA_WIDTH-1:0] w_add;
    logic [DATA_WIDTH-1:0] w_sub;
    logic                  w_ltu;
    logic                  w_lts;
    logic [4:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_lsl;
    logic [DATA_WIDTH-1:0] w_lsr;
    logic [DATA_WIDTH-1:0] w_asr;

    assign w_add   = r_s1_a + r_s1_b;
    assign w_sub   = r_s1_a - r_s1_b;
    assign w_ltu   = r_s1_a < r_s1_b;
    assign w_lts   = $signed(r_s1_a) < $signed(r_s1_b);
    assign w_shamt = r_s1_b[4:0];
    assign w_lsl   = r_s1_a << w_shamt;
    assign w_lsr   = r_s1_a >> w_shamt;
    assign w_asr   = $signed(r_s1_a) >>> w_shamt;

    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_illegal;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        w_result  = '0;
        w_illegal = 1'b0;
        case (r_s1_op)
            OP_ADD:  w_result = w_add;
            OP_SUB:  w_result = w_sub;
            OP_SLTU: w_result = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
            OP_SLTS: w_result = {{(DATA_WIDTH-1){1'b0}}, w_lts};
            OP_AND:  w_result = r_s1_a & r_s1_b;
            OP_OR:   w_result = r_s1_a | r_s1_b;
            OP_XOR:  w_result = r_s1_a ^ r_s1_b;
            OP_LSL:  w_result = w_lsl;
            OP_LSR:  w_result = w_lsr;
            OP_ASR:  w_result = w_asr;
            default: w_illegal = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // NOTE: operand registers are few and cleared on reset so S1 never starts from X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_op  <= '0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_tag <= '0;
        end else if (w_accept) begin
            r_s1_op  <= in_op;
            r_s1_a   <= in_a;
            r_s1_b   <= in_b;
            r_s1_tag <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Result data only moves when S1 advances; a stalled result stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_result  <= '0;
            r_out_tag     <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_result  <= w_result;
            r_out_tag     <= r_s1_tag;
            r_out_illegal <= w_illegal;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_tag     = r_out_tag;
    assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: accepted ops push hand-computed results into a queue,
// an output monitor pops and compares every result consumed by write-back.
module tb_alu_exec_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  tag;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    logic [31:0] exp_result;
    logic        exp_illegal;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acc    = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   rx_cyc[$];
    vec_t vecs[16];

    alu_exec_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid    = 1'b1;
        in_op       = v.op;
        in_a        = v.a;
        in_b        = v.b;
        in_tag      = v.tag;
        exp_result  = v.exp;
        exp_illegal = v.ill;
    endtask

    // Drives consecutive vectors until n of them have been accepted, within a cycle budget.
    task automatic send_n(input int first, input int n);
        int sent   = 0;
        int budget = 20;
        while (sent < n && budget > 0) begin
            drive(vecs[first + sent]);
            if (in_ready) sent++;
            tick();
            budget--;
        end
        in_valid = 1'b0;
        check("send_accepted", sent, n);
    endtask

    task automatic wait_drain();
        int budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_empty", sb.size(), 0);
        tick();
    endtask

    // Input side: record the expected response of every op the stage accepts.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && in_valid && in_ready) begin
                sb.push_back('{exp_result, in_tag, exp_illegal});
                n_acc++;
            end
        end
    end

    // Output side: every result consumed by write-back is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got result 0x%08h tag %0d, expected no result", out_result, out_tag);
                end else begin
                    e = sb.pop_front();
                    check("sb_result", out_result, e.result);
                    check("sb_tag", 32'(out_tag), 32'(e.tag));
                    check("sb_illegal", 32'(out_illegal), 32'(e.illegal));
                    rx_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int base;
        int acc0;

        //            op     a             b             tag    expected      illegal
        vecs[0]  = '{4'd0, 32'h0000_0005, 32'h0000_0007, 5'd1,  32'h0000_000C, 1'b0};
        vecs[1]  = '{4'd1, 32'h0000_0003, 32'h0000_0005, 5'd2,  32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{4'd3, 32'h8000_0000, 32'h0000_0001, 5'd3,  32'h0000_0001, 1'b0};
        vecs[3]  = '{4'd2, 32'h8000_0000, 32'h0000_0001, 5'd4,  32'h0000_0000, 1'b0};
        vecs[4]  = '{4'd9, 32'h8000_0000, 32'h0000_0024, 5'd5,  32'hF800_0000, 1'b0};
        vecs[5]  = '{4'd7, 32'h0000_0001, 32'h0000_001F, 5'd6,  32'h8000_0000, 1'b0};
        vecs[6]  = '{4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7,  32'hF000_F000, 1'b0};
        vecs[7]  = '{4'd5, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd8,  32'hFFFF_F0F0, 1'b0};
        vecs[8]  = '{4'd6, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd9,  32'h5555_AAAA, 1'b0};
        vecs[9]  = '{4'd8, 32'h8000_0000, 32'h0000_003F, 5'd10, 32'h0000_0001, 1'b0};
        vecs[10] = '{4'd9, 32'h7000_0000, 32'h0000_0004, 5'd11, 32'h0700_0000, 1'b0};
        vecs[11] = '{4'd3, 32'h0000_0001, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1'b0};
        vecs[12] = '{4'd2, 32'h0000_0001, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001, 1'b0};
        vecs[13] = '{4'd1, 32'h0000_0000, 32'h0000_0001, 5'd14, 32'hFFFF_FFFF, 1'b0};
        vecs[14] = '{4'd12, 32'h0000_0005, 32'h0000_0007, 5'd20, 32'h0000_0000, 1'b1};
        vecs[15] = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3,  32'h0000_0000, 1'b0};

        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_op       = '0;
        in_a        = '0;
        in_b        = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        exp_result  = '0;
        exp_illegal = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", 32'(out_tag), 0);
        check("rst_out_illegal", 32'(out_illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_reset", 32'(in_ready), 1);

        // Wrapping ADD with two-edge latency
        out_ready = 1'b1;
        drive(vecs[15]);
        tick();
        in_valid = 1'b0;
        check("lat_not_yet_valid", 32'(out_valid), 0);
        tick();
        check("lat_out_valid", 32'(out_valid), 1);
        check("add_wrap_result", out_result, 32'h0000_0000);
        check("add_wrap_tag", 32'(out_tag), 3);
        check("add_wrap_illegal", 32'(out_illegal), 0);
        tick();
        check("lat_valid_drops", 32'(out_valid), 0);

        // Back-to-back stream of all legal vectors
        base = rx_cyc.size();
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i]);
            check("stream_in_ready", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        wait_drain();
        check("stream_count", rx_cyc.size() - base, 14);
        if (rx_cyc.size() - base == 14)
            check("stream_no_bubbles", rx_cyc[base + 13] - rx_cyc[base], 13);

        // Stall: exactly two ops buffer, result held stable
        out_ready = 1'b0;
        acc0 = n_acc;
        send_n(0, 2);
        drive(vecs[2]);
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready_low", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_result_held", out_result, vecs[0].exp);
            check("stall_tag_held", 32'(out_tag), 32'(vecs[0].tag));
            tick();
        end
        in_valid = 1'b0;
        check("stall_accepted_two", n_acc - acc0, 2);
        base = rx_cyc.size();
        out_ready = 1'b1;
        wait_drain();
        check("stall_drained_two", rx_cyc.size() - base, 2);

        // Flush with both stages full and a new op offered
        out_ready = 1'b0;
        send_n(2, 2);
        drive(vecs[4]);
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", 32'(in_ready), 0);
        acc0 = n_acc;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid_low", 32'(out_valid), 0);
        check("flush_input_dropped", n_acc - acc0, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_s1_empty", 32'(out_valid), 0);
        end
        base = rx_cyc.size();
        send_n(5, 1);
        wait_drain();
        check("post_flush_result", rx_cyc.size() - base, 1);

        // Illegal op code
        drive(vecs[14]);
        tick();
        in_valid = 1'b0;
        tick();
        check("illegal_valid", 32'(out_valid), 1);
        check("illegal_result", out_result, 0);
        check("illegal_flag", 32'(out_illegal), 1);
        check("illegal_tag", 32'(out_tag), 20);
        wait_drain();

        // Asynchronous reset in the middle of a stream
        for (int k = 6; k < 10; k++) begin
            drive(vecs[k]);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_result", out_result, 0);
        check("async_rst_tag", 32'(out_tag), 0);
        in_valid = 1'b0;
        sb.delete();
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 3; k++) begin
            check("post_rst_no_stale", 32'(out_valid), 0);
            tick();
        end
        base = rx_cyc.size();
        send_n(10, 1);
        wait_drain();
        check("post_rst_result", rx_cyc.size() - base, 1);

        check("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
